// File: rtl/map_ss_pkg.sv
// Shared definitions for the mapper save-state sequencer.
//   - FSM state encodings (legacy-style 4-bit constants plus a state type)
//   - error codes reported on err
//   - default ss_addr of the map_idx register
//   - helper that maps a walk index onto the mapper's ss_addr space
package map_ss_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_S_RD   = 4'd1;
    localparam state_t ST_S_BUF  = 4'd2;
    localparam state_t ST_R_CHK  = 4'd3;
    localparam state_t ST_R_BUF  = 4'd4;
    localparam state_t ST_R_HI   = 4'd5;
    localparam state_t ST_R_FALL = 4'd6;
    localparam state_t ST_FIN    = 4'd7;
    localparam state_t ST_ERR    = 4'd8;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_IDX  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    localparam int IDX_ADDR_DEF = 127;

    // Walk index n_regs is the map_idx slot, which lives at idx_addr in the
    // mapper window; every other index addresses its register directly.
    function automatic logic [7:0] ss_addr_for(input logic [7:0] idx,
                                               input int n_regs,
                                               input int idx_addr);
        return (idx == 8'(n_regs)) ? 8'(idx_addr) : idx;
    endfunction

endpackage

// File: rtl/map_ss_seq_m2_edge_sync.sv
// m2_edge_sync: brings the NES M2 clock into the clk domain.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous reset, active high
//   m2_i       raw M2, asynchronous to clk_i
//   m2_s_o     M2 after a 2-flop synchronizer
//   m2_fall_o  one-clk pulse when m2_s_o goes 1 -> 0
module m2_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic m2_i,
    output logic m2_s_o,
    output logic m2_fall_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            meta_q     <= m2_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign m2_s_o    = sync_q;
    assign m2_fall_o = sync_dly_q & ~sync_q;

endmodule

// File: rtl/map_ss_seq.sv
// map_ss_seq: save-state sequencer for one mapper core.
// SAVE walks ss_addr 0..N_REGS-1 plus the map_idx register and streams every
// byte into the host buffer. RESTORE checks map_idx against the buffer, then
// writes the buffer back, each ss_we pulse spanning one falling edge of M2
// (mapper registers latch on negedge m2).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m2                       NES M2 (asynchronous)
//   cmd_start, cmd_restore   command pulse and mode (0 save, 1 restore)
//   busy, done, err          status; err held until the next accepted command
//   ss_act, ss_we, ss_addr,
//   ss_wdat, ss_rdat         mapper save-state bus
//   buf_req, buf_we, buf_addr,
//   buf_wdat, buf_rdat, buf_ack  host buffer bus
//   dbg_state                current FSM state
//
// Buffer handshake: buf_req is the valid; once raised, buf_we/buf_addr/
// buf_wdat hold still until a clk edge samples buf_ack=1 (the ready), and
// that edge completes the access (buf_rdat is taken at the same edge).
// buf_ack seen while buf_req=0 completes nothing.
module map_ss_seq
    import map_ss_pkg::*;
#(
    parameter int N_REGS   = 3,
    parameter int IDX_ADDR = IDX_ADDR_DEF,
    parameter int RD_WAIT  = 2,
    parameter int M2_TMO   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m2,
    input  logic       cmd_start,
    input  logic       cmd_restore,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic       buf_req,
    output logic       buf_we,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdat,
    input  logic [7:0] buf_rdat,
    input  logic       buf_ack,
    output logic [3:0] dbg_state
);

    localparam logic [7:0]  LAST_IDX = 8'(N_REGS);
    localparam logic [7:0]  LAST_WR  = 8'(N_REGS - 1);
    localparam logic [7:0]  IDX_A    = 8'(IDX_ADDR);
    localparam logic [10:0] RD_LAST  = 11'(RD_WAIT - 1);
    localparam logic [10:0] TMO_LAST = 11'(M2_TMO - 1);
    // An m2_fall seen in the first two R_FALL cycles belongs to an M2 edge
    // that happened before ss_we rose, so it cannot have latched the write.
    localparam logic [10:0] FALL_QUAL = 11'd2;

    logic m2_s;
    logic m2_fall;

    m2_edge_sync u_m2_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .m2_i     (m2),
        .m2_s_o   (m2_s),
        .m2_fall_o(m2_fall)
    );

    state_t      state_q,    state_d;
    logic [7:0]  idx_q,      idx_d;
    logic [10:0] cnt_q,      cnt_d;
    logic [1:0]  err_q,      err_d;
    logic        ss_act_q,   ss_act_d;
    logic        ss_we_q,    ss_we_d;
    logic [7:0]  ss_addr_q,  ss_addr_d;
    logic [7:0]  ss_wdat_q,  ss_wdat_d;
    logic        buf_req_q,  buf_req_d;
    logic        buf_we_q,   buf_we_d;
    logic [7:0]  buf_addr_q, buf_addr_d;
    logic [7:0]  buf_wdat_q, buf_wdat_d;
    logic        ackd_q,     ackd_d;
    logic [7:0]  chk_q,      chk_d;

    logic       ack;
    logic       have_idx;
    logic [7:0] buf_idx;

    assign ack      = buf_ack & buf_req_q;
    // In R_CHK the buffer byte may arrive before or after RD_WAIT expires.
    assign have_idx = ackd_q | ack;
    assign buf_idx  = ackd_q ? chk_q : buf_rdat;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ss_act_d   = ss_act_q;
        ss_we_d    = ss_we_q;
        ss_addr_d  = ss_addr_q;
        ss_wdat_d  = ss_wdat_q;
        buf_req_d  = buf_req_q;
        buf_we_d   = buf_we_q;
        buf_addr_d = buf_addr_q;
        buf_wdat_d = buf_wdat_q;
        ackd_d     = ackd_q;
        chk_d      = chk_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    err_d    = ERR_NONE;
                    idx_d    = 8'd0;
                    cnt_d    = 11'd0;
                    ss_act_d = 1'b1;
                    if (cmd_restore) begin
                        ss_addr_d  = IDX_A;
                        buf_req_d  = 1'b1;
                        buf_we_d   = 1'b0;
                        buf_addr_d = LAST_IDX;
                        ackd_d     = 1'b0;
                        state_d    = ST_R_CHK;
                    end else begin
                        ss_addr_d = ss_addr_for(8'd0, N_REGS, IDX_ADDR);
                        state_d   = ST_S_RD;
                    end
                end
            end

            ST_S_RD: begin
                if (cnt_q == RD_LAST) begin
                    buf_wdat_d = ss_rdat;
                    buf_req_d  = 1'b1;
                    buf_we_d   = 1'b1;
                    buf_addr_d = idx_q;
                    state_d    = ST_S_BUF;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            ST_S_BUF: begin
                if (ack) begin
                    buf_req_d = 1'b0;
                    buf_we_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        ss_act_d = 1'b0;
                        state_d  = ST_FIN;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        ss_addr_d = ss_addr_for(idx_q + 8'd1, N_REGS, IDX_ADDR);
                        cnt_d     = 11'd0;
                        state_d   = ST_S_RD;
                    end
                end
            end

            ST_R_CHK: begin
                if (cnt_q != RD_LAST) begin
                    cnt_d = cnt_q + 11'd1;
                end
                if (ack) begin
                    buf_req_d = 1'b0;
                    ackd_d    = 1'b1;
                    chk_d     = buf_rdat;
                end
                if (have_idx && cnt_q == RD_LAST) begin
                    if (ss_rdat != buf_idx) begin
                        err_d    = ERR_IDX;
                        ss_act_d = 1'b0;
                        state_d  = ST_ERR;
                    end else begin
                        idx_d      = 8'd0;
                        buf_req_d  = 1'b1;
                        buf_we_d   = 1'b0;
                        buf_addr_d = 8'd0;
                        state_d    = ST_R_BUF;
                    end
                end
            end

            ST_R_BUF: begin
                if (ack) begin
                    buf_req_d = 1'b0;
                    ss_wdat_d = buf_rdat;
                    ss_addr_d = idx_q;
                    cnt_d     = 11'd0;
                    state_d   = ST_R_HI;
                end
            end

            ST_R_HI: begin
                // ss_addr/ss_wdat were loaded on entry, so they have been
                // stable for at least one clk before ss_we can rise here.
                if (m2_s) begin
                    ss_we_d = 1'b1;
                    cnt_d   = 11'd0;
                    state_d = ST_R_FALL;
                end else if (cnt_q == TMO_LAST) begin
                    err_d    = ERR_TMO;
                    ss_we_d  = 1'b0;
                    ss_act_d = 1'b0;
                    state_d  = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            ST_R_FALL: begin
                if (m2_fall && cnt_q >= FALL_QUAL) begin
                    ss_we_d = 1'b0;
                    if (idx_q == LAST_WR) begin
                        ss_act_d = 1'b0;
                        state_d  = ST_FIN;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        buf_req_d  = 1'b1;
                        buf_we_d   = 1'b0;
                        buf_addr_d = idx_q + 8'd1;
                        state_d    = ST_R_BUF;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    err_d    = ERR_TMO;
                    ss_we_d  = 1'b0;
                    ss_act_d = 1'b0;
                    state_d  = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            ST_FIN: state_d = ST_IDLE;

            ST_ERR: state_d = ST_IDLE;

            default: begin
                ss_act_d  = 1'b0;
                ss_we_d   = 1'b0;
                buf_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 8'd0;
            cnt_q      <= 11'd0;
            err_q      <= ERR_NONE;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            ss_addr_q  <= 8'd0;
            ss_wdat_q  <= 8'd0;
            buf_req_q  <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= 8'd0;
            buf_wdat_q <= 8'd0;
            ackd_q     <= 1'b0;
            chk_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ss_act_q   <= ss_act_d;
            ss_we_q    <= ss_we_d;
            ss_addr_q  <= ss_addr_d;
            ss_wdat_q  <= ss_wdat_d;
            buf_req_q  <= buf_req_d;
            buf_we_q   <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_wdat_q <= buf_wdat_d;
            ackd_q     <= ackd_d;
            chk_q      <= chk_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign ss_act    = ss_act_q;
    assign ss_we     = ss_we_q;
    assign ss_addr   = ss_addr_q;
    assign ss_wdat   = ss_wdat_q;
    assign buf_req   = buf_req_q;
    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdat  = buf_wdat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_map_ss_seq.sv
module tb_map_ss_seq;
    import map_ss_pkg::*;

    logic       clk;
    logic       rst;
    logic       m2;
    logic       cmd_start;
    logic       cmd_restore;
    logic       busy;
    logic       done;
    logic [1:0] err;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic       buf_req;
    logic       buf_we;
    logic [7:0] buf_addr;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat;
    logic       buf_ack;
    logic [3:0] dbg_state;

    map_ss_seq dut (
        .clk        (clk),
        .rst        (rst),
        .m2         (m2),
        .cmd_start  (cmd_start),
        .cmd_restore(cmd_restore),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ss_act     (ss_act),
        .ss_we      (ss_we),
        .ss_addr    (ss_addr),
        .ss_wdat    (ss_wdat),
        .ss_rdat    (ss_rdat),
        .buf_req    (buf_req),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdat   (buf_wdat),
        .buf_rdat   (buf_rdat),
        .buf_ack    (buf_ack),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / m2 ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic m2_hold;
    int   falls_in_we;
    // M2 toggles at 3+140k ns, never on a clk edge.
    initial begin
        m2 = 1'b0;
        #3;
        forever begin
            #140;
            if (m2_hold) m2 = 1'b1;
            else         m2 = ~m2;
        end
    end

    // ---------------- mapper model ----------------
    logic [7:0]  mreg [0:2];
    logic [7:0]  mapidx;
    logic [15:0] mw_log[$];

    always_comb begin
        ss_rdat = 8'h00;
        if (ss_addr == 8'd127)   ss_rdat = mapidx;
        else if (ss_addr < 8'd3) ss_rdat = mreg[ss_addr[1:0]];
    end

    always @(negedge m2) begin
        if (ss_act && ss_we) begin
            falls_in_we = falls_in_we + 1;
            if (ss_addr < 8'd3) mreg[ss_addr[1:0]] = ss_wdat;
            mw_log.push_back({ss_addr, ss_wdat});
        end
    end

    // ---------------- buffer model ----------------
    logic [7:0]  bufm [0:255];
    logic [15:0] bw_log[$];
    int          ack_dly;

    initial begin
        buf_ack  = 1'b0;
        buf_rdat = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst || buf_ack) begin
                buf_ack = 1'b0;
            end else if (buf_req) begin
                repeat (ack_dly) begin
                    @(posedge clk);
                    #1;
                end
                if (buf_req && !rst) begin
                    buf_ack  = 1'b1;
                    buf_rdat = bufm[buf_addr];
                    if (buf_we) begin
                        bufm[buf_addr] = buf_wdat;
                        bw_log.push_back({buf_addr, buf_wdat});
                    end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          n_total;
    int          n_bad;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_log(input string tag, input bit use_mw);
        logic [15:0] g;
        check_eq({tag, "_count"}, use_mw ? mw_log.size() : bw_log.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            if (use_mw) g = (mw_log.size() > 0) ? mw_log.pop_front() : 16'hxxxx;
            else        g = (bw_log.size() > 0) ? bw_log.pop_front() : 16'hxxxx;
            check_eq({tag, "_entry"}, g, exp_q.pop_front());
        end
    endtask

    // ---------------- bus monitor ----------------
    int         done_cnt;
    int         we_rises;
    int         falls_at_rise;
    logic       prev_we, prev_req, prev_ack, prev_bwe;
    logic [7:0] prev_addr, prev_wdat, rise_addr, rise_dat, prev_baddr, prev_bwdat;

    always @(negedge clk) begin
        if (rst) begin
            prev_we  = 1'b0;
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (done) done_cnt = done_cnt + 1;
            if (ss_we && !prev_we) begin
                we_rises = we_rises + 1;
                check_eq("we_setup_addr", ss_addr, prev_addr);
                check_eq("we_setup_dat", ss_wdat, prev_wdat);
                rise_addr     = ss_addr;
                rise_dat      = ss_wdat;
                falls_at_rise = falls_in_we;
            end
            if (ss_we && prev_we) begin
                check_eq("we_held_addr", ss_addr, rise_addr);
                check_eq("we_held_dat", ss_wdat, rise_dat);
            end
            if (!ss_we && prev_we && err == ERR_NONE) begin
                check_eq("we_one_fall", falls_in_we - falls_at_rise, 1);
                check_eq("we_after_addr", ss_addr, rise_addr);
                check_eq("we_after_dat", ss_wdat, rise_dat);
            end
            if (buf_req && prev_req && !prev_ack) begin
                check_eq("buf_addr_hold", buf_addr, prev_baddr);
                check_eq("buf_wdat_hold", buf_wdat, prev_bwdat);
                check_eq("buf_we_hold", buf_we, prev_bwe);
            end
            prev_we    = ss_we;
            prev_req   = buf_req;
            prev_ack   = buf_ack;
            prev_bwe   = buf_we;
            prev_baddr = buf_addr;
            prev_bwdat = buf_wdat;
        end
        prev_addr = ss_addr;
        prev_wdat = ss_wdat;
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic restore);
        @(negedge clk);
        cmd_start   = 1'b1;
        cmd_restore = restore;
        @(negedge clk);
        cmd_start   = 1'b0;
        cmd_restore = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic clear_logs();
        mw_log.delete();
        bw_log.delete();
        exp_q.delete();
        done_cnt = 0;
        we_rises = 0;
    endtask

    // ---------------- directed tests ----------------
    int cyc;

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_restore = 1'b0;
        m2_hold = 1'b0; ack_dly = 0; mapidx = 8'd0;
        n_total = 0; n_bad = 0; falls_in_we = 0; falls_at_rise = 0;
        for (int i = 0; i < 3; i++) mreg[i] = 8'h00;
        for (int i = 0; i < 256; i++) bufm[i] = 8'h00;
        clear_logs();

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ss_act", ss_act, 1'b0);
        check_eq("rst_buf_req", buf_req, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_state", dbg_state, ST_IDLE);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, ERR_NONE);
        check_eq("rst_ss_we", ss_we, 1'b0);
        check_eq("rst_ss_addr", ss_addr, 8'd0);

        // 1: save
        mreg[0] = 8'h0B; mreg[1] = 8'h34; mreg[2] = 8'h85; mapidx = 8'd50;
        start_cmd(1'b0);
        check_eq("t1_busy", busy, 1'b1);
        check_eq("t1_ss_act", ss_act, 1'b1);
        wait_idle("t1", 500, cyc);
        exp_q.push_back({8'd0, 8'h0B});
        exp_q.push_back({8'd1, 8'h34});
        exp_q.push_back({8'd2, 8'h85});
        exp_q.push_back({8'd3, 8'd50});
        check_log("t1_bufw", 1'b0);
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_err", err, ERR_NONE);
        check_eq("t1_ss_act_end", ss_act, 1'b0);

        // 2: restore
        clear_logs();
        mreg[0] = 8'h11; mreg[1] = 8'h22; mreg[2] = 8'h33;
        bufm[0] = 8'h05; bufm[1] = 8'hFF; bufm[2] = 8'h9F; bufm[3] = 8'd50;
        start_cmd(1'b1);
        wait_idle("t2", 3000, cyc);
        exp_q.push_back({8'd0, 8'h05});
        exp_q.push_back({8'd1, 8'hFF});
        exp_q.push_back({8'd2, 8'h9F});
        check_log("t2_mapw", 1'b1);
        check_eq("t2_we_pulses", we_rises, 3);
        check_eq("t2_reg2", mreg[2], 8'h9F);
        check_eq("t2_done", done_cnt, 1);
        check_eq("t2_err", err, ERR_NONE);
        check_eq("t2_ss_we_end", ss_we, 1'b0);

        // 3: restore with map_idx mismatch
        clear_logs();
        bufm[3] = 8'd49;
        start_cmd(1'b1);
        wait_idle("t3", 500, cyc);
        check_eq("t3_err", err, ERR_IDX);
        check_eq("t3_we_pulses", we_rises, 0);
        check_eq("t3_ss_act", ss_act, 1'b0);
        check_eq("t3_done", done_cnt, 0);
        check_eq("t3_mapw", mw_log.size(), 0);

        // 4: restore with m2 stuck high
        clear_logs();
        bufm[3] = 8'd50;
        m2_hold = 1'b1;
        repeat (40) @(negedge clk);
        start_cmd(1'b1);
        wait_idle("t4", 1300, cyc);
        check_eq("t4_err", err, ERR_TMO);
        check_eq("t4_window", (cyc >= 1023 && cyc <= 1060), 1'b1);
        check_eq("t4_ss_we", ss_we, 1'b0);
        check_eq("t4_ss_act", ss_act, 1'b0);
        check_eq("t4_done", done_cnt, 0);
        m2_hold = 1'b0;

        // 5: cmd_start mid-save ignored, slow buffer acks
        clear_logs();
        ack_dly = 5;
        mreg[0] = 8'hA5; mreg[1] = 8'h5A; mreg[2] = 8'hC3; mapidx = 8'h4D;
        start_cmd(1'b0);
        repeat (6) @(negedge clk);
        check_eq("t5_busy_mid", busy, 1'b1);
        start_cmd(1'b1);
        wait_idle("t5", 1000, cyc);
        exp_q.push_back({8'd0, 8'hA5});
        exp_q.push_back({8'd1, 8'h5A});
        exp_q.push_back({8'd2, 8'hC3});
        exp_q.push_back({8'd3, 8'h4D});
        check_log("t5_bufw", 1'b0);
        check_eq("t5_done", done_cnt, 1);
        check_eq("t5_err", err, ERR_NONE);
        check_eq("t5_we_pulses", we_rises, 0);
        ack_dly = 0;

        // 6: reset during R_FALL, then a fresh save
        clear_logs();
        bufm[0] = 8'h01; bufm[1] = 8'h02; bufm[2] = 8'h03; bufm[3] = 8'h4D;
        start_cmd(1'b1);
        cyc = 0;
        while (dbg_state != ST_R_FALL && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("t6_reach_fall", dbg_state, ST_R_FALL);
        rst = 1'b1;
        #1;
        check_eq("t6_ss_act", ss_act, 1'b0);
        check_eq("t6_ss_we", ss_we, 1'b0);
        check_eq("t6_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        mreg[0] = 8'h77; mreg[1] = 8'h88; mreg[2] = 8'h99; mapidx = 8'd50;
        start_cmd(1'b0);
        wait_idle("t6", 500, cyc);
        exp_q.push_back({8'd0, 8'h77});
        exp_q.push_back({8'd1, 8'h88});
        exp_q.push_back({8'd2, 8'h99});
        exp_q.push_back({8'd3, 8'd50});
        check_log("t6_bufw", 1'b0);
        check_eq("t6_done", done_cnt, 1);
        check_eq("t6_err", err, ERR_NONE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
